// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_sequencer
// Brief   : Iterative RV32M multiply/divide unit with its sequencing FSM.
//           Shift-add multiply and restoring divide, one bit per cycle, with
//           a one-cycle fast path for divide-by-zero and signed overflow.
// Revision: 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_rd,
  input  logic             flush,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_data,
  output logic [TAG_W-1:0] rsp_rd,
  output logic             busy,
  output logic             stall_req
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  C_MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [TAG_W-1:0] rd_q, rd_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  // hi/lo: product high/low halves for multiply, remainder/quotient for divide
  logic [XLEN-1:0]  hi_q, hi_d;
  logic [XLEN-1:0]  lo_q, lo_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic [XLEN-1:0]  rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0] rsp_rd_q, rsp_rd_d;

  logic             w_accept, w_a_signed, w_b_signed, w_sign_a, w_sign_b;
  logic             w_b_zero, w_ovf;
  logic [XLEN-1:0]  w_mag_a, w_mag_b, w_fast_res;
  logic [XLEN:0]    w_sum, w_rsh;
  logic [XLEN-1:0]  w_diff;
  logic             w_ge;
  logic [2*XLEN-1:0] w_prod, w_prod_fix;
  logic [XLEN-1:0]  w_quo, w_rem, w_fix_res;

  assign req_ready = (state_q == S_IDLE) && !flush;
  assign rsp_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign stall_req = req_valid && !req_ready;
  assign rsp_data  = rsp_data_q;
  assign rsp_rd    = rsp_rd_q;
  assign w_accept  = req_valid && req_ready;

  // Operand decode, datapath step and FSM next-state
  always_comb begin
    // request decode: MULHSU treats only rs1 as signed, *U ops neither
    w_a_signed = (req_op == 3'b000) || (req_op == 3'b001) || (req_op == 3'b010) ||
                 (req_op == 3'b100) || (req_op == 3'b110);
    w_b_signed = (req_op == 3'b000) || (req_op == 3'b001) ||
                 (req_op == 3'b100) || (req_op == 3'b110);
    w_sign_a   = w_a_signed && req_a[XLEN-1];
    w_sign_b   = w_b_signed && req_b[XLEN-1];
    w_mag_a    = w_sign_a ? -req_a : req_a;
    w_mag_b    = w_sign_b ? -req_b : req_b;
    w_b_zero   = (req_b == '0);
    w_ovf      = ((req_op == 3'b100) || (req_op == 3'b110)) &&
                 (req_a == C_MIN_NEG) && (req_b == '1);
    // req_op[1] distinguishes REM* from DIV* on the divide side
    if (w_b_zero) w_fast_res = req_op[1] ? req_a : '1;
    else          w_fast_res = req_op[1] ? '0 : C_MIN_NEG;

    // shift-add step: add multiplicand when the current multiplier bit is set
    w_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    // restoring step: shift in the next dividend bit and trial-subtract
    w_rsh  = {hi_q, lo_q[XLEN-1]};
    w_ge   = (w_rsh >= {1'b0, b_q});
    w_diff = w_rsh[XLEN-1:0] - b_q;

    // sign correction and result selection
    w_prod     = {hi_q, lo_q};
    w_prod_fix = (sign_a_q ^ sign_b_q) ? -w_prod : w_prod;
    w_quo      = (sign_a_q ^ sign_b_q) ? -lo_q : lo_q;
    w_rem      = sign_a_q ? -hi_q : hi_q;
    if (op_q[2])              w_fix_res = op_q[1] ? w_rem : w_quo;
    else if (op_q[1:0] == 2'b00) w_fix_res = w_prod_fix[XLEN-1:0];
    else                      w_fix_res = w_prod_fix[2*XLEN-1:XLEN];

    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    rd_d       = rd_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    b_d        = b_q;
    rsp_data_d = rsp_data_q;
    rsp_rd_d   = rsp_rd_q;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          op_d     = req_op;
          rd_d     = req_rd;
          sign_a_d = w_sign_a;
          sign_b_d = w_sign_b;
          hi_d     = '0;
          lo_d     = w_mag_a;
          b_d      = w_mag_b;
          cnt_d    = '0;
          if (req_op[2] && (w_b_zero || w_ovf)) begin
            rsp_data_d = w_fast_res;
            rsp_rd_d   = req_rd;
            state_d    = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (op_q[2]) begin
          hi_d = w_ge ? w_diff : w_rsh[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], w_ge};
        end else begin
          hi_d = w_sum[XLEN:1];
          lo_d = {w_sum[0], lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_LAST_STEP) state_d = S_FIX;
      end
      S_FIX: begin
        rsp_data_d = w_fix_res;
        rsp_rd_d   = rd_q;
        state_d    = S_DONE;
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // a redirect kills whatever is in flight, including an unconsumed result
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // State and datapath registers, asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      rsp_rd_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      b_q        <= b_d;
      rsp_data_q <= rsp_data_d;
      rsp_rd_q   <= rsp_rd_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_muldiv_sequencer
// Brief   : Directed vector table plus hand-written flush, backpressure and
//           reset sequences for muldiv_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010,
                         OP_MULHU = 3'b011, OP_DIV = 3'b100, OP_DIVU = 3'b101,
                         OP_REM = 3'b110, OP_REMU = 3'b111;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [4:0]  req_rd;
  logic        flush;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        busy, stall_req;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  muldiv_sequencer #(.XLEN(32), .TAG_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_rd    (req_rd),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_rd    (rsp_rd),
    .busy      (busy),
    .stall_req (stall_req)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int lat);
    vec_t v;
    v.name = nm; v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Present one op from a negedge until it is accepted, then drop req_valid.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rd = rd;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Count negedges after the accept edge until rsp_valid (1 = fast path).
  task automatic wait_rsp(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
    end while (!rsp_valid && lat < 100);
  endtask

  task automatic run_vec(input vec_t v, input logic [4:0] rd);
    int lat, bcnt;
    issue(v.op, v.a, v.b, rd);
    wait_rsp(lat, bcnt);
    check({v.name, " data"}, rsp_data, v.exp);
    check({v.name, " rd"}, {27'd0, rsp_rd}, {27'd0, rd});
    check({v.name, " latency"}, lat, v.lat);
    check({v.name, " busy cycles"}, bcnt, v.lat);
    @(negedge clk);
    check({v.name, " idle after handshake"}, {30'd0, busy, rsp_valid}, 32'd0);
  endtask

  initial begin : main
    int lat, bcnt, seen;
    vec_t v;

    add("MUL 7*-3",        OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    add("MULHU -1*-1",     OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    add("MULH -1*-1",      OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34);
    add("MULHSU -1*max",   OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
    add("MUL shift",       OP_MUL,    32'h12345678, 32'h00000010, 32'h23456780, 34);
    add("MULH min*2",      OP_MULH,   32'h80000000, 32'h00000002, 32'hFFFFFFFF, 34);
    add("MULHU 2^31*4",    OP_MULHU,  32'h80000000, 32'h00000004, 32'h00000002, 34);
    add("DIV -7/2",        OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
    add("REM -7%2",        OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
    add("DIVU 100/7",      OP_DIVU,   32'd100,      32'd7,        32'd14,       34);
    add("REMU 100%7",      OP_REMU,   32'd100,      32'd7,        32'd2,        34);
    add("DIV 7/-2",        OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34);
    add("REM 7%-2",        OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        34);
    add("DIVU 2^31/max",   OP_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'd0,        34);
    add("REMU 2^31%max",   OP_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34);
    add("DIVU max/1",      OP_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 34);
    add("DIV 5/0",         OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1);
    add("REM 5%0",         OP_REM,    32'd5,        32'd0,        32'd5,        1);
    add("DIVU 5/0",        OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1);
    add("REMU 9%0",        OP_REMU,   32'd9,        32'd0,        32'd9,        1);
    add("DIV ovf",         OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    add("REM ovf",         OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    reset = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_rd = '0;
    flush = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset rsp_data", rsp_data, 32'd0);
    check("reset rsp_rd", {27'd0, rsp_rd}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset req_ready", {31'd0, req_ready}, 32'd1);
    check("reset stall_req", {31'd0, stall_req}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      run_vec(v, 5'((i % 31) + 1));
    end

    // flush during CALC step 10: op discarded, no response ever appears
    issue(OP_MUL, 32'd3, 32'd5, 5'd7);
    repeat (11) @(negedge clk);
    flush = 1'b1;
    #1 check("flush busy before", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush busy after", {31'd0, busy}, 32'd0);
    check("flush rsp_valid after", {31'd0, rsp_valid}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("flush no response", seen, 32'd0);

    // flush in IDLE blocks an accept and stalls upstream
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_op = OP_MUL; req_a = 32'd2; req_b = 32'd2;
    #1 check("flush idle req_ready", {31'd0, req_ready}, 32'd0);
    check("flush idle stall_req", {31'd0, stall_req}, 32'd1);
    @(posedge clk);
    #1 flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("flush idle no accept", {31'd0, busy}, 32'd0);
    v.name = "post-flush MULHU"; v.op = OP_MULHU; v.a = 32'h80000000; v.b = 32'd4;
    v.exp = 32'd2; v.lat = 34;
    run_vec(v, 5'd12);

    // backpressure in DONE: result held, upstream op stalled, no same-cycle re-accept
    rsp_ready = 1'b0;
    issue(OP_DIVU, 32'd100, 32'd7, 5'd9);
    wait_rsp(lat, bcnt);
    check("hold latency", lat, 32'd34);
    req_valid = 1'b1; req_op = OP_MUL; req_a = 32'd2; req_b = 32'd3; req_rd = 5'd4;
    #1 check("hold stall_req", {31'd0, stall_req}, 32'd1);
    repeat (5) begin
      @(negedge clk);
      check("hold rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold rsp_data", rsp_data, 32'd14);
      check("hold rsp_rd", {27'd0, rsp_rd}, 32'd9);
      check("hold req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("after hold idle", {30'd0, busy, rsp_valid}, 32'd0);
    check("after hold req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp(lat, bcnt);
    check("stalled op data", rsp_data, 32'd6);
    check("stalled op rd", {27'd0, rsp_rd}, 32'd4);
    check("stalled op latency", lat, 32'd34);

    // asynchronous reset in the middle of CALC
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 5'd17);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1 check("midreset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midreset rsp_data", rsp_data, 32'd0);
    check("midreset rsp_rd", {27'd0, rsp_rd}, 32'd0);
    check("midreset busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid || busy) seen++;
    end
    check("midreset no response", seen, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
